serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sersub_pkg.sv | 12 +
 rtl/serial_subtractor_bit.sv | 15 +
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package sersub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SERSUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_bit.sv
// Combinational one-bit full subtractor used for each serial step.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock; results published only on completion.
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int unsigned WIDTH = SERSUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] sh_next;

    // Operands shift right so the active bit is always at position 0; MSBs are kept for ovf.
    full_subtractor_bit u_bit (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        sh_next = (sh_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    sh_d    = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_bout;
                sh_d  = sh_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = sh_next;
                    bout_d  = bit_bout;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        busy = busy_q;
        done = done_q;
        diff = diff_q;
        bout = bout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;
    logic       busy1, done1, bout1, ovf1;
    logic [0:0] diff1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_prev = '0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void ref_sub(input int w, input longint unsigned av, input longint unsigned bv,
                                    output longint unsigned d, output logic bo, output logic ov);
        longint half, sa, sb, sd;
        longint unsigned m;
        half = longint'(1) << (w - 1);
        m    = (longint'(1) << w) - 1;
        sa   = (av >= longint'(half)) ? longint'(av) - 2 * half : longint'(av);
        sb   = (bv >= longint'(half)) ? longint'(bv) - 2 * half : longint'(bv);
        sd   = sa - sb;
        d    = (av - bv) & m;
        bo   = (av < bv);
        ov   = (sd < -half) || (sd >= half);
    endfunction

    task automatic launch8(input logic [7:0] ta, input logic [7:0] tb_v, input bit keep_start);
        @(negedge clk);
        a8 = ta; b8 = tb_v; start8 = 1'b1;
        @(posedge clk); #1;
        check("busy_after_accept", busy8, 1'b1);
        if (!keep_start) start8 = 1'b0;
    endtask

    task automatic wait_done8(input bit disturb, output int edges);
        edges = 0;
        for (int k = 1; k <= 20; k++) begin
            if (disturb && (k == 2 || k == 5)) begin
                a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
            end else if (disturb) begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            if (done8) begin
                edges = k;
                break;
            end
            if (k == 4) begin
                check("diff_held_in_run", diff8, exp_prev);
                check("busy_in_run", busy8, 1'b1);
            end
        end
    endtask

    task automatic check_result8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v, input int edges);
        longint unsigned d;
        logic bo, ov;
        ref_sub(8, ta, tb_v, d, bo, ov);
        check({tag, "_latency"}, edges, 8);
        check({tag, "_diff"}, diff8, d);
        check({tag, "_bout"}, bout8, bo);
        check({tag, "_ovf"}, ovf8, ov);
        check({tag, "_busy_low"}, busy8, 1'b0);
        exp_prev = d[7:0];
    endtask

    initial begin
        int e;
        logic [7:0] ra, rb;
        bit saw_done;

        rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_diff", diff8, 8'h00);
        check("rst_bout", bout8, 1'b0);
        check("rst_ovf", ovf8, 1'b0);
        check("rst_w1_diff", diff1, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        launch8(8'h05, 8'h03, 1'b0);
        wait_done8(1'b0, e);
        check_result8("sub_05_03", 8'h05, 8'h03, e);
        @(posedge clk); #1;
        check("done_one_cycle", done8, 1'b0);
        check("diff_held_after_done", diff8, 8'h02);
        repeat (2) @(posedge clk);
        #1;
        check("diff_held_idle", diff8, 8'h02);

        launch8(8'h03, 8'h05, 1'b0);
        wait_done8(1'b0, e);
        check_result8("sub_03_05", 8'h03, 8'h05, e);

        launch8(8'h80, 8'h01, 1'b0);
        wait_done8(1'b0, e);
        check_result8("sub_80_01", 8'h80, 8'h01, e);

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            launch8(ra, rb, 1'b0);
            wait_done8(1'b0, e);
            check_result8("sub_rand", ra, rb, e);
        end

        ra = 8'($urandom); rb = 8'($urandom);
        launch8(ra, rb, 1'b0);
        wait_done8(1'b1, e);
        check_result8("sub_disturbed", ra, rb, e);
        start8 = 1'b0;

        // Back-to-back: start stays high into the DONE cycle with new operands.
        launch8(8'h10, 8'h20, 1'b1);
        wait_done8(1'b0, e);
        check_result8("b2b_first", 8'h10, 8'h20, e);
        a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        check("b2b_accept_busy", busy8, 1'b1);
        check("b2b_accept_done_low", done8, 1'b0);
        start8 = 1'b0;
        wait_done8(1'b0, e);
        check_result8("b2b_second", 8'hFF, 8'hFF, e);

        launch8(8'h5A, 8'hC3, 1'b0);
        repeat (3) @(posedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_diff", diff8, 8'h00);
        check("abort_bout", bout8, 1'b0);
        check("abort_ovf", ovf8, 1'b0);
        exp_prev = '0;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);
        launch8(8'h5A, 8'hC3, 1'b0);
        wait_done8(1'b0, e);
        check_result8("after_abort", 8'h5A, 8'hC3, e);

        for (int i = 0; i < 4; i++) begin
            longint unsigned d;
            logic bo, ov;
            int edges;
            logic [1:0] combo;
            combo = 2'(i);
            @(negedge clk);
            a1 = combo[1]; b1 = combo[0]; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            edges = 0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                if (done1) begin
                    edges = k;
                    break;
                end
            end
            ref_sub(1, longint'(combo[1]), longint'(combo[0]), d, bo, ov);
            check("w1_latency", edges, 1);
            check("w1_diff", diff1, d);
            check("w1_bout", bout1, bo);
            check("w1_ovf", ovf1, ov);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
